// File: rtl/pipelined_addsub.sv
`default_nettype none
// ============================================================================
// Module      : pipelined_addsub
// Description : Parametrised pipelined add/subtract unit. The operand width is
//               split into STAGES equal segments; each pipeline stage computes
//               one ripple-carry segment and registers the carry for the next
//               stage. Valid/ready handshakes on both sides give full
//               throughput and back-pressure with bubble collapsing.
// Ports       : clk        - rising-edge clock
//               rst_n      - asynchronous active-low reset
//               in_valid   - operand beat valid
//               in_ready   - unit can accept a beat this cycle
//               a, b       - operands (unsigned or two's complement)
//               cin        - carry-in (add) / borrow-in (sub)
//               sub        - 0: a+b+cin, 1: a-b-cin
//               out_valid  - result beat valid
//               out_ready  - consumer accepts the result this cycle
//               sum        - result modulo 2^WIDTH
//               cout       - carry-out (add) / borrow-out (sub)
//               ovf        - signed two's-complement overflow
// Revision    : 1.0 - initial release
// ============================================================================
module pipelined_addsub #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int SEG = WIDTH / STAGES;

    // Per-stage register contents, exported so the following stage and the
    // output logic can read them.
    logic [STAGES-1:0] w_v;
    logic [STAGES-1:0] w_free;
    logic [WIDTH-1:0]  w_a_q   [STAGES];
    logic [WIDTH-1:0]  w_bb_q  [STAGES];
    logic [WIDTH-1:0]  w_sum_q [STAGES];
    logic              w_c_q   [STAGES];
    logic              w_sub_q [STAGES];

    // Subtraction is a + ~b + ~cin, so the borrow-in becomes an inverted carry-in.
    logic [WIDTH-1:0]  w_bb0;
    logic              w_c0;

    assign w_bb0 = sub ? ~b : b;
    assign w_c0  = sub ? ~cin : cin;

    // Stage k may load when it is empty or its content moves on. Unrolled, the
    // chain "free[k] = ~v[k] | free[k+1]" collapses to out_ready OR any empty
    // stage at or beyond k, which is computed with a running accumulator.
    always_comb begin : p_free
        logic acc;
        acc    = out_ready;
        w_free = '0;
        for (int k = STAGES - 1; k >= 0; k--) begin
            acc       = acc | ~w_v[k];
            w_free[k] = acc;
        end
    end

    assign in_ready = w_free[0];

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic             w_vin;
        logic [WIDTH-1:0] w_a_in;
        logic [WIDTH-1:0] w_bb_in;
        logic [WIDTH-1:0] w_sum_in;
        logic             w_c_in;
        logic             w_sub_in;
        logic [SEG:0]     w_seg;
        logic [WIDTH-1:0] w_sum_nx;
        logic             w_load;

        logic             r_v;
        logic [WIDTH-1:0] r_a;
        logic [WIDTH-1:0] r_bb;
        logic [WIDTH-1:0] r_sum;
        logic             r_c;
        logic             r_sub;

        if (k == 0) begin : g_first
            assign w_vin    = in_valid;
            assign w_a_in   = a;
            assign w_bb_in  = w_bb0;
            assign w_sum_in = '0;
            assign w_c_in   = w_c0;
            assign w_sub_in = sub;
        end else begin : g_next
            assign w_vin    = w_v[k-1];
            assign w_a_in   = w_a_q[k-1];
            assign w_bb_in  = w_bb_q[k-1];
            assign w_sum_in = w_sum_q[k-1];
            assign w_c_in   = w_c_q[k-1];
            assign w_sub_in = w_sub_q[k-1];
        end

        // One ripple-carry segment; the top bit is the carry into the next stage.
        assign w_seg = {1'b0, w_a_in[k*SEG +: SEG]}
                     + {1'b0, w_bb_in[k*SEG +: SEG]}
                     + {{SEG{1'b0}}, w_c_in};

        always_comb begin
            w_sum_nx                = w_sum_in;
            w_sum_nx[k*SEG +: SEG]  = w_seg[SEG-1:0];
        end

        // Data only moves with a real beat so a drained pipe keeps its last
        // (or reset) values instead of latching idle-bus garbage.
        assign w_load = w_free[k] & w_vin;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_v   <= 1'b0;
                r_a   <= '0;
                r_bb  <= '0;
                r_sum <= '0;
                r_c   <= 1'b0;
                r_sub <= 1'b0;
            end else begin
                if (w_free[k]) begin
                    r_v <= w_vin;
                end
                if (w_load) begin
                    r_a   <= w_a_in;
                    r_bb  <= w_bb_in;
                    r_sum <= w_sum_nx;
                    r_c   <= w_seg[SEG];
                    r_sub <= w_sub_in;
                end
            end
        end

        assign w_v[k]     = r_v;
        assign w_a_q[k]   = r_a;
        assign w_bb_q[k]  = r_bb;
        assign w_sum_q[k] = r_sum;
        assign w_c_q[k]   = r_c;
        assign w_sub_q[k] = r_sub;
    end

    // Outputs come straight from the last stage registers, so they hold
    // stable whenever that stage is stalled.
    assign out_valid = w_v[STAGES-1];
    assign sum       = w_sum_q[STAGES-1];
    assign cout      = w_sub_q[STAGES-1] ^ w_c_q[STAGES-1];
    assign ovf       = (w_a_q[STAGES-1][WIDTH-1] == w_bb_q[STAGES-1][WIDTH-1])
                     & (w_sum_q[STAGES-1][WIDTH-1] != w_a_q[STAGES-1][WIDTH-1]);

endmodule
`default_nettype wire

// File: tb/tb_pipelined_addsub.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipelined_addsub
// Description : Self-checking bench for pipelined_addsub (WIDTH=16, STAGES=4):
//               reset, directed arithmetic corners, back-pressure streaming,
//               reset mid-stream and a randomised handshake soak.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipelined_addsub;

    localparam int WIDTH  = 16;
    localparam int STAGES = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [WIDTH-1:0]  a;
    logic [WIDTH-1:0]  b;
    logic              cin;
    logic              sub;
    logic              out_valid;
    logic              out_ready;
    logic [WIDTH-1:0]  sum;
    logic              cout;
    logic              ovf;

    int n_checks = 0;
    int n_fail   = 0;

    pipelined_addsub #(
        .WIDTH  (WIDTH),
        .STAGES (STAGES)
    ) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        n_checks++;
        if (observed !== expected) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Independent reference: integer arithmetic on the true operands.
    function automatic logic [17:0] model(input logic [15:0] ma, input logic [15:0] mb,
                                          input logic mc, input logic ms);
        logic [16:0] r;
        int          sr;
        logic        o;
        if (ms) begin
            r  = {1'b0, ma} - {1'b0, mb} - {16'd0, mc};
            sr = int'($signed(ma)) - int'($signed(mb)) - int'(mc);
        end else begin
            r  = {1'b0, ma} + {1'b0, mb} + {16'd0, mc};
            sr = int'($signed(ma)) + int'($signed(mb)) + int'(mc);
        end
        o = (sr > 32767) || (sr < -32768);
        return {o, r[16], r[15:0]};
    endfunction

    // Presents one beat (caller is just after a rising edge) and waits for it.
    task automatic send_one(input string tag, input logic [15:0] ta, input logic [15:0] tb_,
                            input logic tc, input logic ts, input logic [15:0] esum,
                            input logic ecout, input logic eovf);
        int lat;
        lat       = 0;
        a         = ta;
        b         = tb_;
        cin       = tc;
        sub       = ts;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        check_value({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        for (int n = 1; n <= 10; n++) begin
            @(posedge clk);
            #1;
            if (n == 1) in_valid = 1'b0;
            if (out_valid) begin
                lat = n;
                break;
            end
        end
        check_value({tag, "_latency"}, 32'(lat), 32'(STAGES));
        check_value({tag, "_sum"}, 32'(sum), 32'(esum));
        check_value({tag, "_cout_ovf"}, 32'({cout, ovf}), 32'({ecout, eovf}));
    endtask

    initial begin : p_main
        int  sent;
        int  rcv;
        int  stray;
        bit  saw_full;
        logic [17:0] exp_q[$];
        logic [17:0] exp_v;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        cin       = 1'b0;
        sub       = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check_value("rst_out_valid", 32'(out_valid), 32'd0);
        check_value("rst_sum", 32'(sum), 32'd0);
        check_value("rst_cout_ovf", 32'({cout, ovf}), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_value("rst_in_ready", 32'(in_ready), 32'd1);

        // Directed arithmetic corners
        send_one("add_wrap",  16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        send_one("add_sovf",  16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
        send_one("sub_sovf",  16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b0, 1'b1);
        send_one("sub_brw",   16'h0003, 16'h0005, 1'b0, 1'b1, 16'hFFFE, 1'b1, 1'b0);
        send_one("sub_brw_c", 16'h0003, 16'h0005, 1'b1, 1'b1, 16'hFFFD, 1'b1, 1'b0);
        send_one("add_cin",   16'h1234, 16'h1111, 1'b1, 1'b0, 16'h2346, 1'b0, 1'b0);
        send_one("sub_eq",    16'h5555, 16'h5555, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0);
        send_one("add_seg",   16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0);
        @(posedge clk);
        #1;

        // Back-pressure: 10 beats, consumer stalled for cycles 3..9
        sent     = 0;
        rcv      = 0;
        saw_full = 1'b0;
        for (int c = 0; c < 60; c++) begin
            in_valid  = (sent < 10);
            a         = 16'h0100 + 16'(sent);
            b         = 16'(sent);
            cin       = 1'b0;
            sub       = 1'b0;
            out_ready = !(c >= 3 && c <= 9);
            @(negedge clk);
            if (!in_ready && !saw_full) begin
                saw_full = 1'b1;
                check_value("bp_depth", 32'(sent), 32'd4);
            end
            if (c == 10) check_value("bp_full_accept", 32'(in_ready), 32'd1);
            if (out_valid) check_value("bp_data", 32'(sum), 32'(16'h0100 + 16'(2 * rcv)));
            if (in_valid && in_ready) sent++;
            if (out_valid && out_ready) rcv++;
            @(posedge clk);
            #1;
            if (rcv == 10) break;
        end
        check_value("bp_count", 32'(rcv), 32'd10);
        check_value("bp_saw_full", 32'(saw_full), 32'd1);
        in_valid = 1'b0;

        // Reset mid-stream: load the pipe while stalled, then reset
        out_ready = 1'b0;
        a         = 16'h1234;
        b         = 16'h1111;
        cin       = 1'b0;
        sub       = 1'b0;
        in_valid  = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check_value("mid_pre_valid", 32'(out_valid), 32'd1);
        check_value("mid_pre_sum", 32'(sum), 32'h2345);
        #2;
        rst_n = 1'b0;
        #1;
        check_value("mid_rst_valid", 32'(out_valid), 32'd0);
        check_value("mid_rst_sum", 32'(sum), 32'd0);
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        check_value("mid_rel_ready", 32'(in_ready), 32'd1);
        stray = 0;
        repeat (8) begin
            @(posedge clk);
            #1;
            if (out_valid) stray++;
        end
        check_value("mid_no_stale", 32'(stray), 32'd0);

        // Random handshake soak against the arithmetic model
        sent = 0;
        rcv  = 0;
        for (int c = 0; c < 5000; c++) begin
            in_valid  = (sent < 400) && ($urandom_range(0, 3) != 0);
            a         = 16'($urandom);
            b         = 16'($urandom);
            cin       = 1'($urandom);
            sub       = 1'($urandom);
            out_ready = ($urandom_range(0, 2) != 0);
            @(negedge clk);
            if (in_valid && in_ready) begin
                exp_q.push_back(model(a, b, cin, sub));
                sent++;
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check_value("soak_spurious", 32'(out_valid), 32'd0);
                end else begin
                    exp_v = exp_q.pop_front();
                    check_value("soak_result", 32'({ovf, cout, sum}), 32'(exp_v));
                    rcv++;
                end
            end
            @(posedge clk);
            #1;
            if (sent == 400 && exp_q.size() == 0) break;
        end
        check_value("soak_count", 32'(rcv), 32'd400);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
